// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port round-robin arbiter in front of one SDRAM controller port
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed m0-over-m1 priority instead of round-robin.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 16,
    parameter int BE_W        = 2,
    parameter int MAX_PENDING = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         i_m0_rd_n,
    input  logic                         i_m0_wr_n,
    input  logic [ADDR_W-1:0]            i_m0_addr,
    input  logic [DATA_W-1:0]            i_m0_data,
    input  logic [BE_W-1:0]              i_m0_be_n,
    output logic                         o_m0_wait_req,
    output logic                         o_m0_valid,
    output logic [DATA_W-1:0]            o_m0_data,

    input  logic                         i_m1_rd_n,
    input  logic                         i_m1_wr_n,
    input  logic [ADDR_W-1:0]            i_m1_addr,
    input  logic [DATA_W-1:0]            i_m1_data,
    input  logic [BE_W-1:0]              i_m1_be_n,
    output logic                         o_m1_wait_req,
    output logic                         o_m1_valid,
    output logic [DATA_W-1:0]            o_m1_data,

    output logic                         o_rd_n,
    output logic                         o_wr_n,
    output logic [ADDR_W-1:0]            o_addr,
    output logic [DATA_W-1:0]            o_data,
    output logic [BE_W-1:0]              o_be_n,
    input  logic                         i_wait_req,
    input  logic                         i_valid,
    input  logic [DATA_W-1:0]            i_data,

    output logic [1:0]                   o_grant,
    output logic [$clog2(MAX_PENDING):0] o_pending,
    output logic                         o_error
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_state_t;

    arb_state_t         state_q, state_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic               last_q, last_d;
`endif
    logic [CNT_W-1:0]   pending_q, pending_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [MAX_PENDING-1:0] tag_q, tag_d;
    logic               error_q, error_d;
    logic               m0_valid_q, m0_valid_d;
    logic               m1_valid_q, m1_valid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic pend_full;
    logic m0_req, m0_wr, m0_rd_raw, m0_rd, m0_blk;
    logic m1_req, m1_wr, m1_rd_raw, m1_rd, m1_blk;
    logic accept, accept_rd, rearb, push, pop;

    // A requester driving both strobes is treated as a write; its read is never issued.
    always_comb begin
        pend_full = (pending_q == CNT_MAX);
        m0_req    = !i_m0_rd_n | !i_m0_wr_n;
        m0_wr     = !i_m0_wr_n;
        m0_rd_raw = !i_m0_rd_n & i_m0_wr_n;
        m0_rd     = m0_rd_raw & !pend_full;
        m0_blk    = m0_rd_raw & pend_full;
        m1_req    = !i_m1_rd_n | !i_m1_wr_n;
        m1_wr     = !i_m1_wr_n;
        m1_rd_raw = !i_m1_rd_n & i_m1_wr_n;
        m1_rd     = m1_rd_raw & !pend_full;
        m1_blk    = m1_rd_raw & pend_full;
    end

    always_comb begin
        o_rd_n        = 1'b1;
        o_wr_n        = 1'b1;
        o_addr        = '0;
        o_data        = '0;
        o_be_n        = '1;
        o_m0_wait_req = 1'b1;
        o_m1_wait_req = 1'b1;
        accept        = 1'b0;
        accept_rd     = 1'b0;
        case (state_q)
            ARB_M0: begin
                o_rd_n        = !m0_rd;
                o_wr_n        = !m0_wr;
                o_addr        = i_m0_addr;
                o_data        = i_m0_data;
                o_be_n        = i_m0_be_n;
                o_m0_wait_req = m0_blk | i_wait_req;
                accept        = (m0_rd | m0_wr) & !i_wait_req;
                accept_rd     = m0_rd & !i_wait_req;
            end
            ARB_M1: begin
                o_rd_n        = !m1_rd;
                o_wr_n        = !m1_wr;
                o_addr        = i_m1_addr;
                o_data        = i_m1_data;
                o_be_n        = i_m1_be_n;
                o_m1_wait_req = m1_blk | i_wait_req;
                accept        = (m1_rd | m1_wr) & !i_wait_req;
                accept_rd     = m1_rd & !i_wait_req;
            end
            default: ;
        endcase
    end

    // Re-arbitrate on acceptance, or when the granted requester has withdrawn.
    always_comb begin
        state_d = state_q;
        rearb   = (state_q == ARB_IDLE) | accept
                | ((state_q == ARB_M0) & !m0_req)
                | ((state_q == ARB_M1) & !m1_req);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        if (rearb) begin
            if (m0_req)      state_d = ARB_M0;
            else if (m1_req) state_d = ARB_M1;
            else             state_d = ARB_IDLE;
        end
`else
        last_d = accept ? (state_q == ARB_M1) : last_q;
        if (rearb) begin
            case (state_q)
                ARB_M0: begin
                    if (m1_req)      state_d = ARB_M1;
                    else if (m0_req) state_d = ARB_M0;
                    else             state_d = ARB_IDLE;
                end
                ARB_M1: begin
                    if (m0_req)      state_d = ARB_M0;
                    else if (m1_req) state_d = ARB_M1;
                    else             state_d = ARB_IDLE;
                end
                default: begin
                    if (m0_req & m1_req) state_d = last_q ? ARB_M0 : ARB_M1;
                    else if (m0_req)     state_d = ARB_M0;
                    else if (m1_req)     state_d = ARB_M1;
                    else                 state_d = ARB_IDLE;
                end
            endcase
        end
`endif
    end

    // In-order tag FIFO: one id bit per outstanding read, popped by each controller valid.
    always_comb begin
        push     = accept_rd;
        pop      = i_valid & (pending_q != '0);
        tag_d    = tag_q;
        if (push) tag_d[wr_ptr_q] = (state_q == ARB_M1);
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   pending_d = pending_q + CNT_ONE;
            2'b01:   pending_d = pending_q - CNT_ONE;
            default: pending_d = pending_q;
        endcase
        m0_valid_d = pop & !tag_q[rd_ptr_q];
        m1_valid_d = pop &  tag_q[rd_ptr_q];
        rdata_d    = pop ? i_data : rdata_q;
        error_d    = error_q
                   | (i_valid & (pending_q == '0))
                   | (!i_m0_rd_n & !i_m0_wr_n)
                   | (!i_m1_rd_n & !i_m1_wr_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_q      <= '0;
            error_q    <= 1'b0;
            m0_valid_q <= 1'b0;
            m1_valid_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_q      <= tag_d;
            error_q    <= error_d;
            m0_valid_q <= m0_valid_d;
            m1_valid_q <= m1_valid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_grant    = {state_q == ARB_M1, state_q == ARB_M0};
    assign o_pending  = pending_q;
    assign o_error    = error_q;
    assign o_m0_valid = m0_valid_q;
    assign o_m1_valid = m1_valid_q;
    assign o_m0_data  = rdata_q;
    assign o_m1_data  = rdata_q;

endmodule
